mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 98 +++++++++
 tb/tb_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port byte-maskable memory with a fixed-latency, in-order response pipeline.
// Every accepted request (read or write) returns the word contents as they were
// before that request's own write, exactly Latency cycles after the handshake.
// Optional build macro: MEM_RESPONDER_STALL_EN adds pseudo-random ready_o stalls
// driven by a 16-bit Fibonacci LFSR.
module mem_responder #(
    parameter int unsigned Xlen     = 64,
    parameter int unsigned MaskBits = Xlen / 8,
    parameter int unsigned Depth    = 1024,
    parameter int unsigned Latency  = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                ready_o,
    input  logic                valid_i,
    input  logic [Xlen-1:0]     addr_i,
    input  logic [Xlen-1:0]     wdata_i,
    input  logic [MaskBits-1:0] wmask_i,
    output logic [Xlen-1:0]     rdata_o,
    output logic                rvalid_o
);

    localparam int unsigned OffW = $clog2(MaskBits);
    localparam int unsigned IdxW = $clog2(Depth);

    logic [Xlen-1:0] mem_q [Depth];
    logic            pipe_valid_q [Latency];
    logic [Xlen-1:0] pipe_data_q  [Latency];

    logic            stall;
    logic            handshake;
    logic [IdxW-1:0] idx;
    logic            unused_addr;

    // Byte offset bits and bits above the wrapped index are deliberately dropped.
    always_comb begin
        idx         = addr_i[OffW +: IdxW];
        unused_addr = ^addr_i;
    end

`ifdef MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR, taps 16,14,13,11 in shift-right form; bit 0 requests a stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    always_comb stall = lfsr_q[0];
`else
    always_comb stall = 1'b0;
`endif

    // Ready drops combinationally with reset so nothing is accepted while rst_i is high.
    always_comb begin
        ready_o   = !rst_i && !stall;
        handshake = valid_i && ready_o;
    end

    // Byte-lane write; contents are never reset so data survives rst_i.
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            for (int unsigned b = 0; b < MaskBits; b++) begin
                if (wmask_i[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response shift pipeline; stage 0 captures the pre-write word at the handshake edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Latency; i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_data_q[i]  <= '0;
            end
        end else begin
            pipe_valid_q[0] <= handshake;
            pipe_data_q[0]  <= handshake ? mem_q[idx] : '0;
            for (int unsigned i = 1; i < Latency; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_data_q[i]  <= pipe_data_q[i-1];
            end
        end
    end

    // Outputs are forced quiet during reset and data is zero whenever no strobe.
    always_comb begin
        rvalid_o = !rst_i && pipe_valid_q[Latency-1];
        rdata_o  = rvalid_o ? pipe_data_q[Latency-1] : '0;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (Xlen=64, Depth=1024, Latency=2).
// A scoreboard model predicts ready_o, rvalid_o and rdata_o every cycle; directed
// sequences pin the model with literal expectations. Define MEM_RESPONDER_STALL_EN
// to also exercise random stalls with 1000 held requests.
module tb_mem_responder;

    localparam int unsigned Xlen    = 64;
    localparam int unsigned Depth   = 1024;
    localparam int unsigned Latency = 2;

    logic        clk;
    logic        rst;
    logic        ready;
    logic        valid;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    logic        rvalid;

    mem_responder #(
        .Xlen     (Xlen),
        .MaskBits (8),
        .Depth    (Depth),
        .Latency  (Latency)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .ready_o  (ready),
        .valid_i  (valid),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .wmask_i  (wmask),
        .rdata_o  (rdata),
        .rvalid_o (rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edges  = 0;

    // Model state: memory image, knowledge of each word, pending responses.
    typedef struct {
        int          due;
        logic [63:0] data;
        bit          known;
    } resp_t;

    logic [63:0] m_mem   [Depth];
    bit          m_known [Depth];
    resp_t       exp_q   [$];
    logic [63:0] got_data[$];
    int          got_cyc [$];

`ifdef MEM_RESPONDER_STALL_EN
    logic [15:0] m_lfsr = 16'hACE1;
`endif

    function automatic bit m_ready();
`ifdef MEM_RESPONDER_STALL_EN
        return !rst && !m_lfsr[0];
`else
        return !rst;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edges);
        end
    endtask

    function automatic logic [63:0] got_at(input int i);
        if (i < got_data.size()) return got_data[i];
        return 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < got_cyc.size()) return got_cyc[i];
        return -1000;
    endfunction

    // Model update at each rising edge: accept, snapshot old word, apply lanes.
    always @(posedge clk) begin
        resp_t r;
        int    idx;
        bit    acc;
        edges++;
        acc = m_ready() && valid;
        if (rst) begin
            exp_q.delete();
`ifdef MEM_RESPONDER_STALL_EN
            m_lfsr = 16'hACE1;
`endif
        end else begin
`ifdef MEM_RESPONDER_STALL_EN
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
            if (acc) begin
                idx     = int'(addr[12:3]);
                r.due   = edges + int'(Latency) - 1;
                r.data  = m_mem[idx];
                r.known = m_known[idx];
                exp_q.push_back(r);
                for (int b = 0; b < 8; b++) begin
                    if (wmask[b]) m_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end
                if (wmask == 8'hFF) m_known[idx] = 1'b1;
            end
        end
    end

    // Compare every cycle on the falling edge, after the previous rising edge settled.
    always @(negedge clk) begin
        resp_t e;
        bit    exp_v;
        exp_v = 1'b0;
        e.known = 1'b0;
        e.data  = '0;
        if (exp_q.size() > 0 && exp_q[0].due == edges) begin
            e = exp_q.pop_front();
            exp_v = !rst;
        end
        check("ready", 64'(ready), 64'(m_ready()));
        check("rvalid", 64'(rvalid), 64'(exp_v));
        if (exp_v && e.known) check("rdata", rdata, e.data);
        if (!rvalid) check("rdata_idle", rdata, 64'h0);
        if (rvalid) begin
            got_data.push_back(rdata);
            got_cyc.push_back(edges);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        wmask = 8'h00;
        repeat (n) step();
    endtask

    // Present a request and hold it until accepted (bounded).
    task automatic req(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
        bit done = 1'b0;
        valid = 1'b1;
        addr  = a;
        wdata = d;
        wmask = m;
        for (int t = 0; t < 64 && !done; t++) begin
            done = ready;
            step();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: addr %h never accepted", a);
        end
        valid = 1'b0;
        wmask = 8'h00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int e0;
        rst   = 1'b1;
        valid = 1'b0;
        addr  = '0;
        wdata = '0;
        wmask = '0;
        repeat (3) step();
        check("reset_ready", 64'(ready), 64'h0);
        check("reset_rvalid", 64'(rvalid), 64'h0);
        rst = 1'b0;
        step();
        check("ready_after_reset", 64'(ready), 64'h1);

        // Preload words 0x0, 0x8, 0x18.
        req(64'h0, 64'hA0, 8'hFF);
        req(64'h8, 64'hA8, 8'hFF);
        req(64'h18, 64'hB8, 8'hFF);
        idle(4);

        // Full write then read next cycle: read sees the new data.
        base = got_data.size();
        req(64'h10, 64'h1122_3344_5566_7788, 8'hFF);
        req(64'h10, 64'h0, 8'h00);
        idle(4);
        check("raw_count", 64'(got_data.size() - base), 64'd2);
        check("raw_data", got_at(base + 1), 64'h1122_3344_5566_7788);
`ifndef MEM_RESPONDER_STALL_EN
        check("raw_b2b", 64'(cyc_at(base + 1) - cyc_at(base)), 64'd1);
`endif

        // Partial write: write returns old word, read returns merged word.
        base = got_data.size();
        req(64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        req(64'h10, 64'h0, 8'h00);
        idle(4);
        check("partial_old", got_at(base), 64'h1122_3344_5566_7788);
        check("partial_new", got_at(base + 1), 64'h1122_3344_FFFF_FFFF);

        // Four back-to-back reads, in order, first strobe two edges after handshake.
        base = got_data.size();
        e0   = edges;
        req(64'h0, 64'h0, 8'h00);
        req(64'h8, 64'h0, 8'h00);
        req(64'h10, 64'h0, 8'h00);
        req(64'h18, 64'h0, 8'h00);
        idle(4);
        check("b2b_0", got_at(base), 64'hA0);
        check("b2b_1", got_at(base + 1), 64'hA8);
        check("b2b_2", got_at(base + 2), 64'h1122_3344_FFFF_FFFF);
        check("b2b_3", got_at(base + 3), 64'hB8);
`ifndef MEM_RESPONDER_STALL_EN
        check("b2b_latency", 64'(cyc_at(base) - e0), 64'd2);
        check("b2b_span", 64'(cyc_at(base + 3) - cyc_at(base)), 64'd3);
`endif

        // Index wraps modulo Depth; low address bits ignored.
        base = got_data.size();
        req(64'h2000, 64'hDEAD, 8'hFF);
        req(64'h0, 64'h0, 8'h00);
        req(64'h5, 64'h0, 8'h00);
        idle(4);
        check("wrap_read", got_at(base + 1), 64'hDEAD);
        check("low_bits_ignored", got_at(base + 2), 64'hDEAD);

        // Reset right after a read handshake kills its response; a write during reset is ignored.
        req(64'h8, 64'h0, 8'h00);
        base  = got_data.size();
        rst   = 1'b1;
        valid = 1'b1;
        addr  = 64'h18;
        wdata = 64'hBAD;
        wmask = 8'hFF;
        step();
        step();
        valid = 1'b0;
        wmask = 8'h00;
        rst   = 1'b0;
        step();
        check("reset_drop_now", 64'(got_data.size() - base), 64'd0);
        idle(4);
        check("reset_drop_later", 64'(got_data.size() - base), 64'd0);

        // Memory retained across reset.
        base = got_data.size();
        req(64'h10, 64'h0, 8'h00);
        req(64'h8, 64'h0, 8'h00);
        req(64'h18, 64'h0, 8'h00);
        idle(4);
        check("retain_10", got_at(base), 64'h1122_3344_FFFF_FFFF);
        check("retain_08", got_at(base + 1), 64'hA8);
        check("retain_18", got_at(base + 2), 64'hB8);

`ifdef MEM_RESPONDER_STALL_EN
        // Random held requests under stall injection; the scoreboard checks each response.
        for (int i = 0; i < 1000; i++) begin
            logic [63:0] a;
            logic [63:0] d;
            logic [7:0]  m;
            a = 64'($urandom_range(0, 31)) * 64'd8 + 64'($urandom_range(0, 7));
            d = {$urandom, $urandom};
            m = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            req(a, d, m);
        end
        idle(8);
`endif

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
